// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default parameters for game flow control
//
// Purpose : state enum for game_flow_fsm, default parameter values and the
//           bit positions of the registered indicator vector.
// Ports   : none (package).
package game_pkg;

  localparam int DEF_NUM_LEVELS    = 4;
  localparam int DEF_NUM_LIVES     = 3;
  localparam int DEF_SPLASH_CYCLES = 50_000_000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_PLAY,
    S_PAUSE,
    S_LIFE_LOST,
    S_LOSE,
    S_WIN,
    S_COMPLETE,
    S_RESET_INFO,
    S_NEXT_LEVEL
  } game_state_t;

  // Bit positions inside the registered indicator vector.
  localparam int O_PRESS      = 9;
  localparam int O_INIT       = 8;
  localparam int O_PLAY       = 7;
  localparam int O_PAUSED     = 6;
  localparam int O_LIFE_LOST  = 5;
  localparam int O_WON        = 4;
  localparam int O_LOST       = 3;
  localparam int O_COMPLETE   = 2;
  localparam int O_RESET_INFO = 1;
  localparam int O_NEXT_LEVEL = 0;
  localparam int O_COUNT      = 10;

endpackage

// File: rtl/splash_timer.sv
// rtl/splash_timer.sv - saturating cycle counter measuring time spent in a game state
//
// Purpose : counts cycles since the last clear and flags when SPLASH_CYCLES
//           cycles have elapsed; holds there (no wrap) until cleared.
// Ports   : clk    - system clock
//           resetN - synchronous active-low reset
//           clear  - restart the count (asserted on every state change)
//           done   - SPLASH_CYCLES cycles have elapsed since the last clear
module splash_timer
  import game_pkg::*;
#(
  parameter int SPLASH_CYCLES = DEF_SPLASH_CYCLES
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  output logic done
);

  localparam int CW = $clog2(SPLASH_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(SPLASH_CYCLES));

endmodule

// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - top-level game flow state machine (levels, lives, splash screens)
//
// Purpose : sequences a game through start, board init, play, life loss,
//           level win, game over and game complete, tracking level and lives.
//           Optional pause support is compiled in with macro GAME_PAUSE_EN.
// Ports   : clk, resetN            - clock, synchronous active-low reset
//           startInit              - start/continue request (level-sensitive)
//           initFinished           - board initialisation done
//           win, lose              - level cleared / player hit (PLAY only)
//           pauseReq               - single-cycle pause toggle
//           pressToStart..nextLevel - registered state indicators, one cycle behind state
//           level                  - current level, 0-based
//           livesLeft              - remaining lives
module game_flow_fsm
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
  parameter int NUM_LIVES     = DEF_NUM_LIVES,
  parameter int SPLASH_CYCLES = DEF_SPLASH_CYCLES
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startInit,
  input  logic                               initFinished,
  input  logic                               win,
  input  logic                               lose,
  input  logic                               pauseReq,
  output logic                               pressToStart,
  output logic                               initGame,
  output logic                               playGame,
  output logic                               paused,
  output logic                               lifeLost,
  output logic                               gameWon,
  output logic                               gameLost,
  output logic                               gameComplete,
  output logic                               resetInfo,
  output logic                               nextLevel,
  output logic [$clog2(NUM_LEVELS+1)-1:0]    level,
  output logic [$clog2(NUM_LIVES+1)-1:0]     livesLeft
);

  localparam int LW  = $clog2(NUM_LEVELS + 1);
  localparam int LVW = $clog2(NUM_LIVES + 1);

  game_state_t        state, state_next;
  logic [LW-1:0]      level_next;
  logic [LVW-1:0]     lives_next;
  logic [O_COUNT-1:0] ind_d, ind_q;
  logic               splash_done;
  logic               pause_hit;

`ifdef GAME_PAUSE_EN
  assign pause_hit = pauseReq;
`else
  logic unused_pause;
  assign unused_pause = pauseReq;
  assign pause_hit    = 1'b0;
`endif

  splash_timer #(
    .SPLASH_CYCLES(SPLASH_CYCLES)
  ) u_splash (
    .clk   (clk),
    .resetN(resetN),
    .clear (state_next != state),
    .done  (splash_done)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= S_IDLE;
      ind_q     <= '0;
      level     <= '0;
      livesLeft <= LVW'(NUM_LIVES);
    end else begin
      state     <= state_next;
      ind_q     <= ind_d;
      level     <= level_next;
      livesLeft <= lives_next;
    end
  end

  always_comb begin
    state_next = state;
    level_next = level;
    lives_next = livesLeft;
    ind_d      = '0;

    case (state)
      S_IDLE: begin
        ind_d[O_PRESS] = 1'b1;
        if (startInit) state_next = S_INIT;
      end
      S_INIT: begin
        ind_d[O_INIT] = 1'b1;
        if (initFinished) state_next = S_PLAY;
      end
      S_PLAY: begin
        ind_d[O_PLAY] = 1'b1;
        // A pause request masks win/lose in the same cycle; win beats lose.
        if (pause_hit) begin
          state_next = S_PAUSE;
        end else if (win) begin
          state_next = (level == LW'(NUM_LEVELS - 1)) ? S_COMPLETE : S_WIN;
        end else if (lose) begin
          if (livesLeft != '0) lives_next = livesLeft - LVW'(1);
          state_next = (livesLeft == LVW'(1)) ? S_LOSE : S_LIFE_LOST;
        end
      end
      S_PAUSE: begin
`ifdef GAME_PAUSE_EN
        ind_d[O_PAUSED] = 1'b1;
`endif
        if (pause_hit) state_next = S_PLAY;
      end
      S_LIFE_LOST: begin
        ind_d[O_LIFE_LOST] = 1'b1;
        if (splash_done) state_next = S_INIT;
      end
      S_LOSE: begin
        ind_d[O_LOST] = 1'b1;
        if (splash_done && startInit) state_next = S_RESET_INFO;
      end
      S_COMPLETE: begin
        ind_d[O_COMPLETE] = 1'b1;
        if (splash_done && startInit) state_next = S_RESET_INFO;
      end
      S_WIN: begin
        ind_d[O_WON] = 1'b1;
        if (splash_done && startInit) state_next = S_NEXT_LEVEL;
      end
      S_RESET_INFO: begin
        ind_d[O_LOST]       = 1'b1;
        ind_d[O_RESET_INFO] = 1'b1;
        level_next          = '0;
        lives_next          = LVW'(NUM_LIVES);
        state_next          = S_INIT;
      end
      S_NEXT_LEVEL: begin
        ind_d[O_WON]        = 1'b1;
        ind_d[O_NEXT_LEVEL] = 1'b1;
        if (level < LW'(NUM_LEVELS - 1)) level_next = level + LW'(1);
        state_next          = S_INIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pressToStart = ind_q[O_PRESS];
  assign initGame     = ind_q[O_INIT];
  assign playGame     = ind_q[O_PLAY];
  assign paused       = ind_q[O_PAUSED];
  assign lifeLost     = ind_q[O_LIFE_LOST];
  assign gameWon      = ind_q[O_WON];
  assign gameLost     = ind_q[O_LOST];
  assign gameComplete = ind_q[O_COMPLETE];
  assign resetInfo    = ind_q[O_RESET_INFO];
  assign nextLevel    = ind_q[O_NEXT_LEVEL];

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb/tb_game_flow_fsm.sv - self-checking bench for game_flow_fsm with a behavioural reference model
module tb_game_flow_fsm;

  localparam int NL  = 3;
  localparam int NLV = 3;
  localparam int SPL = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0, startInit = 1'b0, initFinished = 1'b0;
  logic win = 1'b0, lose = 1'b0, pauseReq = 1'b0;
  logic pressToStart, initGame, playGame, paused, lifeLost;
  logic gameWon, gameLost, gameComplete, resetInfo, nextLevel;
  logic [$clog2(NL+1)-1:0]  level;
  logic [$clog2(NLV+1)-1:0] livesLeft;

  int checks   = 0;
  int failures = 0;

  // Reference model: named phase, time spent in it, level, lives, expected indicators.
  string      m_st    = "idle";
  int         m_t     = 0;
  int         m_lvl   = 0;
  int         m_lives = NLV;
  logic [9:0] m_out   = '0;

  always #5 clk = ~clk;

  game_flow_fsm #(
    .NUM_LEVELS(NL), .NUM_LIVES(NLV), .SPLASH_CYCLES(SPL)
  ) dut (
    .clk(clk), .resetN(resetN), .startInit(startInit), .initFinished(initFinished),
    .win(win), .lose(lose), .pauseReq(pauseReq),
    .pressToStart(pressToStart), .initGame(initGame), .playGame(playGame),
    .paused(paused), .lifeLost(lifeLost), .gameWon(gameWon), .gameLost(gameLost),
    .gameComplete(gameComplete), .resetInfo(resetInfo), .nextLevel(nextLevel),
    .level(level), .livesLeft(livesLeft)
  );

  // Indicator order: press, init, play, paused, lifeLost, won, lost, complete, resetInfo, nextLevel
  function automatic logic [9:0] shown(input string st);
    case (st)
      "idle":       return 10'b10_0000_0000;
      "init":       return 10'b01_0000_0000;
      "play":       return 10'b00_1000_0000;
      "pause":      return 10'b00_0100_0000;
      "life_lost":  return 10'b00_0010_0000;
      "win":        return 10'b00_0001_0000;
      "lose":       return 10'b00_0000_1000;
      "complete":   return 10'b00_0000_0100;
      "reset_info": return 10'b00_0000_1010;
      "next_level": return 10'b00_0001_0001;
      default:      return 10'b00_0000_0000;
    endcase
  endfunction

  task automatic model_edge(input logic rn, si, inf, w, l, pr);
    string nx;
    if (!rn) begin
      m_st = "idle"; m_t = 0; m_lvl = 0; m_lives = NLV; m_out = '0;
      return;
    end
    m_out = shown(m_st);
    nx = m_st;
    case (m_st)
      "idle": if (si) nx = "init";
      "init": if (inf) nx = "play";
      "play": begin
`ifdef GAME_PAUSE_EN
        if (pr) nx = "pause";
        else
`endif
        if (w) nx = (m_lvl == NL - 1) ? "complete" : "win";
        else if (l) begin
          nx = (m_lives == 1) ? "lose" : "life_lost";
          if (m_lives > 0) m_lives = m_lives - 1;
        end
      end
      "pause":      if (pr) nx = "play";
      "life_lost":  if (m_t >= SPL) nx = "init";
      "lose":       if (m_t >= SPL && si) nx = "reset_info";
      "complete":   if (m_t >= SPL && si) nx = "reset_info";
      "win":        if (m_t >= SPL && si) nx = "next_level";
      "reset_info": begin m_lvl = 0; m_lives = NLV; nx = "init"; end
      "next_level": begin if (m_lvl < NL - 1) m_lvl = m_lvl + 1; nx = "init"; end
      default:      nx = "idle";
    endcase
    if (nx != m_st) m_t = 0;
    else if (m_t < SPL) m_t = m_t + 1;
    m_st = nx;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {pressToStart, initGame, playGame, paused, lifeLost,
            gameWon, gameLost, gameComplete, resetInfo, nextLevel};
  endfunction

  task automatic step(input logic rn, si, inf, w, l, pr);
    resetN = rn; startInit = si; initFinished = inf; win = w; lose = l; pauseReq = pr;
    @(posedge clk);
    model_edge(rn, si, inf, w, l, pr);
    #1;
    check($sformatf("indicators[%s]", m_st), {22'b0, dut_vec()}, {22'b0, m_out});
    check("level", {30'b0, level}, m_lvl);
    check("livesLeft", {30'b0, livesLeft}, m_lives);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic hold_start(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic to_play();
    step(1, 0, 1, 0, 0, 0);
    idle(1);
  endtask

  initial begin
    // Reset and start-up
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("reset_outputs", {22'b0, dut_vec()}, 32'd0);
    idle(1);
    check("press_after_reset", {31'b0, pressToStart}, 32'd1);
    step(1, 1, 0, 0, 0, 0);
    to_play();
    check("play_reached", {31'b0, playGame}, 32'd1);
    check("start_level", {30'b0, level}, 32'd0);
    check("start_lives", {30'b0, livesLeft}, 32'd3);

    // Three lives lost, game over, restart after splash
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 0, 1, 0);
      idle(6);
      to_play();
    end
    check("lives_after_two", {30'b0, livesLeft}, 32'd1);
    step(1, 0, 0, 0, 1, 0);
    idle(1);
    check("game_lost", {31'b0, gameLost}, 32'd1);
    check("lives_zero", {30'b0, livesLeft}, 32'd0);
    hold_start(8);
    to_play();
    check("lives_restored", {30'b0, livesLeft}, 32'd3);

    // Level progression to game complete
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 1, 0, 0);
      hold_start(7);
      to_play();
    end
    check("level_two", {30'b0, level}, 32'd2);
    step(1, 0, 0, 1, 0, 0);
    idle(1);
    check("complete_shown", {31'b0, gameComplete}, 32'd1);
    check("won_not_shown", {31'b0, gameWon}, 32'd0);
    hold_start(7);
    to_play();
    check("level_wrapped", {30'b0, level}, 32'd0);

    // Win and lose together
    step(1, 0, 0, 1, 1, 0);
    idle(1);
    check("win_priority", {31'b0, gameWon}, 32'd1);
    hold_start(7);
    to_play();

    // Pause toggle (or no effect without pause support)
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    idle(2);

    // Reset in the middle of a win splash
    step(0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0);
    to_play();
    step(1, 0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0);
    check("midsplash_reset", {22'b0, dut_vec()}, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(63) != 0),
           ($urandom_range(2) == 0),
           ($urandom_range(1) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
